imem_loader: RTL

- Boot-time loader sitting directly upstream of the SEQ core's fetch stage.
- Accepts a byte stream over a valid/ready handshake and writes it into instruction memory from address 0 upward.
- Holds the core's PC/clocking in reset (core_hold) until the image is complete.
- Reports a modulo-256 checksum, completion, and error status so the bench or top level can release the core.

---
 rtl/y86_pkg.sv | 23 ++
 rtl/loader_timeout_ctr.sv | 26 ++
 rtl/imem_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the SEQ core boot path: loader state encoding,
// default memory geometry and the processor status codes.
package y86_pkg;

    localparam int ADDR_W_DEF    = 10;
    localparam int MEM_BYTES_DEF = 1024;
    localparam int TIMEOUT_DEF   = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } ld_state_t;

    typedef enum logic [3:0] {
        AOK = 4'b1000,
        HLT = 4'b0010,
        ADR = 4'b0001,
        INS = 4'b0100
    } stat_t;

endpackage

// File: rtl/loader_timeout_ctr.sv
// Idle-cycle counter for the image loader. o_tc fires in the enabled cycle
// that would take the count to TIMEOUT, so the caller can act on that edge.
module loader_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: streams bytes into imem from address 0,
// holds the core until the image is complete, and reports checksum/status.
//
// state | meaning
// IDLE  | waiting for a start pulse, core held
// LOAD  | accepting image bytes, one write per accepted byte
// DONE  | image complete, core released, checksum frozen
// ERR   | bad length or stream timeout, core held, sticky
module imem_loader
    import y86_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_core_hold,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [7:0]        o_checksum
);

    localparam int LEN_W = ADDR_W + 1;

    ld_state_t         r_state;
    ld_state_t         w_state_next;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [7:0]        r_checksum;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_core_hold;
    logic              r_load_done;
    logic              r_load_err;

    logic w_len_ok;
    logic w_start_go;
    logic w_accept;
    logic w_last;
    logic w_tc;
    logic w_to_clr;
    logic w_to_en;

    assign w_len_ok   = (i_len != '0) && (i_len <= LEN_W'(MEM_BYTES));
    assign w_start_go = i_start && (r_state != LOAD) && w_len_ok;
    assign w_accept   = (r_state == LOAD) && i_byte_valid;
    assign w_last     = (r_cnt == (r_len - LEN_W'(1)));

    // An accepted byte restarts the idle window even in the terminal cycle.
    assign w_to_en  = (r_state == LOAD) && !w_accept;
    assign w_to_clr = (r_state != LOAD) || w_accept;

    loader_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clr   (w_to_clr),
        .i_en    (w_to_en),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (i_start) begin
                    w_state_next = w_len_ok ? LOAD : ERR;
                end
            end
            LOAD: begin
                if (w_accept && w_last) begin
                    w_state_next = DONE;
                end else if (w_tc) begin
                    w_state_next = ERR;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_len       <= '0;
            r_cnt       <= '0;
            r_checksum  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_core_hold <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= r_cnt[ADDR_W-1:0];
                r_wr_data <= i_byte_data;
            end
            if (w_start_go) begin
                r_len      <= i_len;
                r_cnt      <= '0;
                r_checksum <= '0;
            end else if (w_accept) begin
                r_cnt      <= r_cnt + LEN_W'(1);
                r_checksum <= r_checksum + i_byte_data;
            end
            // Status follows the state being entered so it changes on the same edge.
            r_core_hold <= (w_state_next != DONE);
            r_load_done <= (w_state_next == DONE);
            r_load_err  <= (w_state_next == ERR);
        end
    end

    assign o_byte_ready = (r_state == LOAD);
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_core_hold  = r_core_hold;
    assign o_load_done  = r_load_done;
    assign o_load_err   = r_load_err;
    assign o_checksum   = r_checksum;

endmodule
